low_to_high_control: RTL and testbench
======================================

Name: low_to_high_control

Overview:
- Measurement controller for the rising (low-to-high) transition of a path under test.
- It drives the path input low, waits for the path output to settle low, and launches a rising edge.
- It then counts clock cycles until the path output is sampled high, and reports the count with a load strobe and a finish flag.
- It pairs with the existing falling-edge controller in the same delay-measurement datapath. Unlike that controller, it has a request/finish handshake, a settle phase and timeout detection.

Parameters:
- CNT_W, 8, width of the cycle counter and of delay_cnt.
- SETTLE_CYCLES, 4, minimum number of cycles pathInput is held low before launch; must be >= 1.
- TIMEOUT, 200, cycle limit for the SETTLE phase and for the MEASURE phase; SETTLE_CYCLES < TIMEOUT <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level request; held high for a whole measurement.
- pathResult  input  1  output of the path under test, sampled directly on clk.
- pathInput  output  1  stimulus driven into the path under test.
- ld_reg  output  1  one-cycle strobe; delay_cnt is valid and should be loaded.
- fin  output  1  measurement complete, valid or timed out.
- timeout  output  1  the finished measurement hit TIMEOUT.
- busy  output  1  high in SETTLE and MEASURE.
- delay_cnt  output  CNT_W  measured cycle count.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - pathInput, ld_reg, fin, timeout and busy all go to 0, and delay_cnt goes to 0.
  - This applies immediately, including mid-measurement.
- Outputs and counter:
  - All outputs are registered.
  - One internal counter, cnt (CNT_W bits), is cleared on every state entry.
- IDLE:
  - pathInput=0, busy=0.
  - start=1 -> SETTLE.
- SETTLE:
  - pathInput=0, busy=1, cnt increments each edge.
  - At an edge where cnt >= SETTLE_CYCLES-1 and pathResult=0 -> MEASURE.
  - Otherwise, at the edge where cnt == TIMEOUT-1 -> DONE with timeout=1 and delay_cnt = all ones. pathInput never rises in this case.
- MEASURE:
  - pathInput=1 from the first cycle of this state, busy=1.
  - The first edge in MEASURE samples with cnt=0; cnt increments each edge.
  - At an edge where pathResult=1: delay_cnt <= cnt, timeout <= 0, ld_reg=1 for exactly the next cycle -> DONE.
  - At the edge where cnt == TIMEOUT-1 and pathResult=0: delay_cnt <= all ones, timeout <= 1, no ld_reg -> DONE.
  - If pathResult=1 and the timeout condition occur on the same edge, pathResult wins (valid capture).
  - Definition: delay_cnt = k when the path equals k register stages of clk; a combinational path gives 0.
- DONE:
  - fin=1, pathInput=1 (held), busy=0.
  - delay_cnt and timeout are held stable.
  - Stays in DONE while start=1. start=0 -> IDLE, and fin, timeout and pathInput clear next cycle.
  - delay_cnt holds its value until the next capture.
- Handshake:
  - start is 4-phase: start=1 -> fin=1 -> start=0 -> fin=0.
  - A new measurement requires start to return low first.
- Abort: start=0 in SETTLE or MEASURE -> IDLE on that edge. No ld_reg, no fin, and delay_cnt/timeout are unchanged.
- ld_reg and fin both assert in the first DONE cycle; ld_reg deasserts after one cycle.
- cnt never wraps, because TIMEOUT bounds it.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle in MEASURE -> all outputs 0 immediately, state IDLE, and pathInput=0 before the next clk edge.
- Normal (CNT_W=8, SETTLE_CYCLES=4, TIMEOUT=20): pathResult = pathInput through 3 clk flops, start=1 -> pathInput low for 4 cycles then high; ld_reg one-cycle pulse; delay_cnt=3, timeout=0, fin=1 held while start=1.
- Zero delay: pathResult wired directly to pathInput -> delay_cnt=0, ld_reg pulses. Repeat with 1 and 7 stages -> delay_cnt 1 and 7.
- MEASURE timeout: pathResult tied 0 -> after 20 MEASURE edges fin=1, timeout=1, delay_cnt=8'hFF, and ld_reg never asserts.
- SETTLE timeout / simultaneous event:
  - pathResult tied 1 -> pathInput stays 0; after 20 cycles fin=1, timeout=1, delay_cnt=8'hFF.
  - Separately, pathResult rising exactly on the cnt=19 MEASURE edge -> delay_cnt=19, timeout=0.
- Handshake/abort:
  - Drop start during MEASURE -> IDLE next edge, pathInput=0, no fin, and the previous delay_cnt is retained.
  - After a DONE, drop start -> fin=0. Re-raise start -> a fresh measurement gives the same delay_cnt=3.

Source files
------------

// File: rtl/low_to_high_control.sv
// low_to_high_control: measures the rising-edge delay of a path under test.
// Drives pathInput low until pathResult settles low, launches a rising edge,
// then counts clk cycles until pathResult is sampled high. The result is
// reported on delay_cnt with a one-cycle ld_reg strobe and a held fin flag.
//
// Handshake: start is a 4-phase level request. The requester raises start and
// holds it; fin rises once the result (valid or timed out) is on delay_cnt and
// timeout; the requester then drops start and fin falls on the next cycle.
// Dropping start before fin aborts the run and leaves delay_cnt/timeout alone.
module low_to_high_control #(
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pathResult,
  output logic             pathInput,
  output logic             ld_reg,
  output logic             fin,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] delay_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] cnt;
  logic             capture;   // pathResult seen high in MEASURE this edge
  logic             expire;    // TIMEOUT reached in SETTLE or MEASURE this edge

  logic             pathInputD;
  logic             ldRegD;
  logic             finD;
  logic             timeoutD;
  logic             busyD;
  logic [CNT_W-1:0] delayCntD;

  // State register and phase counter; cnt restarts at 0 on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (nextState != state) begin
        cnt <= '0;
      end else if (state == SETTLE || state == MEASURE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state logic; abort has priority, then capture, then timeout.
  always_comb begin
    nextState = state;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = SETTLE;
      end
      SETTLE: begin
        if (!start) begin
          nextState = IDLE;
        end else if (cnt >= SETTLE_LAST && !pathResult) begin
          nextState = MEASURE;
        end else if (cnt == TIMEOUT_LAST) begin
          nextState = DONE;
          expire    = 1'b1;
        end
      end
      MEASURE: begin
        if (!start) begin
          nextState = IDLE;
        end else if (pathResult) begin
          nextState = DONE;
          capture   = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          nextState = DONE;
          expire    = 1'b1;
        end
      end
      DONE: begin
        if (!start) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    pathInputD = pathInput;
    ldRegD     = capture;
    finD       = (nextState == DONE);
    busyD      = (nextState == SETTLE) || (nextState == MEASURE);
    timeoutD   = timeout;
    delayCntD  = delay_cnt;
    // pathInput only rises on MEASURE entry, so a SETTLE timeout keeps it low in DONE.
    case (nextState)
      IDLE, SETTLE: pathInputD = 1'b0;
      MEASURE:      pathInputD = 1'b1;
      default:      pathInputD = pathInput;
    endcase
    if (capture) begin
      delayCntD = cnt;
      timeoutD  = 1'b0;
    end else if (expire) begin
      delayCntD = '1;
      timeoutD  = 1'b1;
    end else if (state == DONE && nextState == IDLE) begin
      timeoutD  = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pathInput <= 1'b0;
      ld_reg    <= 1'b0;
      fin       <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      delay_cnt <= '0;
    end else begin
      pathInput <= pathInputD;
      ld_reg    <= ldRegD;
      fin       <= finD;
      timeout   <= timeoutD;
      busy      <= busyD;
      delay_cnt <= delayCntD;
    end
  end

endmodule

// File: tb/tb_low_to_high_control.sv
// tb_low_to_high_control: drives low_to_high_control against a configurable
// path model (delay line of N clk flops, or pathResult tied 0/1) and compares
// each finished measurement with a queued expected {timeout, delay_cnt}.
module tb_low_to_high_control;

  localparam int CNT_W         = 8;
  localparam int SETTLE_CYCLES = 4;
  localparam int TIMEOUT       = 20;
  localparam int SB_W          = CNT_W + 1;

  localparam int MODE_LINE = 0;
  localparam int MODE_TIE0 = 1;
  localparam int MODE_TIE1 = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             pathResult;
  logic             pathInput;
  logic             ld_reg;
  logic             fin;
  logic             timeout;
  logic             busy;
  logic [CNT_W-1:0] delay_cnt;

  int               checks;
  int               errors;
  logic [SB_W-1:0]  exp_q[$];
  logic [SB_W-1:0]  sbEntry;
  logic             finPrev;
  logic [CNT_W-1:0] lastDelay;

  int               mode;
  int               depth;
  logic             flush;
  logic [31:0]      sr;

  low_to_high_control #(
    .CNT_W        (CNT_W),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pathResult(pathResult),
    .pathInput (pathInput),
    .ld_reg    (ld_reg),
    .fin       (fin),
    .timeout   (timeout),
    .busy      (busy),
    .delay_cnt (delay_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Path under test: shift register of clk flops, tap selected by depth
  always @(posedge clk) begin
    if (flush) sr <= '0;
    else       sr <= {sr[30:0], pathInput};
  end

  always_comb begin
    case (mode)
      MODE_TIE0: pathResult = 1'b0;
      MODE_TIE1: pathResult = 1'b1;
      default:   pathResult = (depth == 0) ? pathInput : sr[depth-1];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare the oldest expected result on the first fin cycle
  always @(negedge clk) begin
    if (fin && !finPrev) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_fin", 1, 0);
      end else begin
        sbEntry = exp_q.pop_front();
        check("sb_delay_cnt", delay_cnt, sbEntry[CNT_W-1:0]);
        check("sb_timeout", timeout, sbEntry[CNT_W]);
        check("sb_ld_reg", ld_reg, !sbEntry[CNT_W]);
      end
    end
    finPrev <= fin;
  end

  task automatic flush_path(input int m, input int d);
    mode  = m;
    depth = d;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Full measurement: request, wait for fin, hold, release
  task automatic run_meas(input int m, input int d);
    logic            expTo;
    logic [SB_W-1:0] expv;
    int              lowCnt;
    int              hiCnt;
    int              holdCycles;
    logic            done;
    flush_path(m, d);
    expTo = (m != MODE_LINE) || (d > TIMEOUT - 1);
    expv  = expTo ? {1'b1, {CNT_W{1'b1}}} : {1'b0, CNT_W'(d)};
    exp_q.push_back(expv);
    start  = 1'b1;
    lowCnt = 0;
    hiCnt  = 0;
    done   = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (fin) begin
        done = 1'b1;
      end else begin
        if (busy && !pathInput) lowCnt++;
        if (busy && pathInput)  hiCnt++;
      end
    end
    check("fin_seen", done, 1);
    check("settle_len", lowCnt, (m == MODE_TIE1) ? TIMEOUT : SETTLE_CYCLES);
    check("measure_len", hiCnt, (m == MODE_TIE1) ? 0 : (expTo ? TIMEOUT : d + 1));
    check("pathInput_done", pathInput, (m == MODE_TIE1) ? 0 : 1);
    check("busy_done", busy, 0);
    holdCycles = $urandom_range(1, 4);
    for (int j = 0; j < holdCycles; j++) begin
      @(negedge clk);
      check("fin_hold", fin, 1);
      check("ld_reg_one_cycle", ld_reg, 0);
      check("delay_hold", delay_cnt, expv[CNT_W-1:0]);
      check("timeout_hold", timeout, expv[CNT_W]);
    end
    start = 1'b0;
    @(negedge clk);
    check("fin_clear", fin, 0);
    check("pathInput_clear", pathInput, 0);
    check("timeout_clear", timeout, 0);
    check("delay_kept", delay_cnt, expv[CNT_W-1:0]);
    lastDelay = expv[CNT_W-1:0];
  endtask

  // Wait until the DUT is in MEASURE (busy with pathInput high), bounded
  task automatic wait_measure(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (busy && pathInput) seen = 1'b1;
    end
    check("reach_measure", seen, 1);
  endtask

  // Drop start mid-MEASURE: back to idle without fin or a new result
  task automatic run_abort();
    logic seen;
    flush_path(MODE_LINE, 10);
    start = 1'b1;
    wait_measure(seen);
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_pathInput", pathInput, 0);
    check("abort_fin", fin, 0);
    check("abort_ld_reg", ld_reg, 0);
    check("abort_delay_kept", delay_cnt, lastDelay);
    check("abort_timeout", timeout, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_stay_idle", fin | busy, 0);
    end
  endtask

  // Asynchronous reset in the middle of MEASURE
  task automatic run_reset_mid();
    logic seen;
    flush_path(MODE_LINE, 10);
    start = 1'b1;
    wait_measure(seen);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pathInput", pathInput, 0);
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_ld_reg", ld_reg, 0);
    check("rst_timeout", timeout, 0);
    check("rst_delay_cnt", delay_cnt, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_idle", {busy, fin, pathInput}, 0);
    end
    lastDelay = '0;
  endtask

  // Main sequence and final report
  initial begin
    checks  = 0;
    errors  = 0;
    finPrev = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b1;
    mode    = MODE_LINE;
    depth   = 0;
    lastDelay = '0;
    repeat (3) @(negedge clk);
    check("init_pathInput", pathInput, 0);
    check("init_busy", busy, 0);
    check("init_fin", fin, 0);
    check("init_ld_reg", ld_reg, 0);
    check("init_timeout", timeout, 0);
    check("init_delay_cnt", delay_cnt, 0);
    rst_n = 1'b1;
    flush = 1'b0;
    @(negedge clk);

    run_meas(MODE_LINE, 3);
    run_meas(MODE_LINE, 0);
    run_meas(MODE_LINE, 1);
    run_meas(MODE_LINE, 7);
    run_meas(MODE_TIE0, 0);
    run_meas(MODE_TIE1, 0);
    run_meas(MODE_LINE, 19);
    run_meas(MODE_LINE, 20);
    run_meas(MODE_LINE, 3);
    run_abort();
    run_meas(MODE_LINE, 3);
    for (int r = 0; r < 6; r++) begin
      run_meas(MODE_LINE, $urandom_range(0, 22));
    end
    run_reset_mid();
    run_meas(MODE_LINE, 5);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
